// File: rtl/rle_pkg.sv
// rle_pkg: shared widths, run-word layout and FSM states for the RLE expander.
package rle_pkg;
    localparam int VALUE_W = 8;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic [CNT_W-1:0]   count;
        logic [VALUE_W-1:0] value;
    } rle_word_t;

    typedef enum logic [0:0] {IDLE, RUN} state_t;
endpackage

// File: rtl/rle_stat_cnt.sv
// rle_stat_cnt: 32-bit wrapping event counter with enable and synchronous clear.
module rle_stat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (en) q <= q + 32'd1;
endmodule

// File: rtl/rle_expand.sv
// rle_expand: expands {count, value} run words into a byte stream; RLE_EXPAND_STATS_EN adds byte/run counters.
module rle_expand #(
    parameter int VALUE_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W+VALUE_W-1:0] in_data,
    input  logic                     in_avail,
    output logic                     in_read,
    output logic [VALUE_W-1:0]       out_data,
    output logic                     out_write,
    input  logic                     out_full,
    output logic                     busy
`ifdef RLE_EXPAND_STATS_EN
    ,
    output logic [31:0]              stat_bytes,
    output logic [31:0]              stat_runs
`endif
);
    import rle_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   count;
    logic [VALUE_W-1:0] value_q;

    assign count     = in_data[CNT_W+VALUE_W-1:VALUE_W];
    // Lookahead pop on the last byte of a run keeps runs back-to-back.
    assign in_read   = !rst && in_avail && (state == IDLE || (state == RUN && remaining == CNT_W'(1) && !out_full));
    assign out_write = !rst && state == RUN && !out_full;
    assign out_data  = value_q;
    assign busy      = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            value_q   <= '0;
        end else if (in_read) begin
            value_q   <= in_data[VALUE_W-1:0];
            remaining <= count;
            state     <= count != '0 ? RUN : IDLE;
        end else if (out_write) begin
            remaining <= remaining - CNT_W'(1);
            state     <= remaining == CNT_W'(1) ? IDLE : RUN;
        end
    end

`ifdef RLE_EXPAND_STATS_EN
    rle_stat_cnt u_bytes (.clk(clk), .rst(rst), .en(out_write), .q(stat_bytes));
    rle_stat_cnt u_runs  (.clk(clk), .rst(rst), .en(in_read && count != '0), .q(stat_runs));
`endif
endmodule

// File: tb/tb_rle_expand.sv
// tb_rle_expand: directed scoreboard bench for rle_expand (stats checked when RLE_EXPAND_STATS_EN is defined).
module tb_rle_expand;
    import rle_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] in_data = '0;
    logic        in_avail = 0;
    logic        in_read;
    logic [7:0]  out_data;
    logic        out_write;
    logic        out_full = 0;
    logic        busy;
`ifdef RLE_EXPAND_STATS_EN
    logic [31:0] stat_bytes, stat_runs;
`endif

    rle_expand dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_avail(in_avail), .in_read(in_read),
        .out_data(out_data), .out_write(out_write), .out_full(out_full), .busy(busy)
`ifdef RLE_EXPAND_STATS_EN
        , .stat_bytes(stat_bytes), .stat_runs(stat_runs)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] src[$];
    logic [7:0]  expq[$];
    int passed = 0, total = 0;
    int np, nw, nco;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    task automatic refresh();
        in_avail = src.size() != 0;
        if (in_avail) in_data = src[0];
        else in_data = '0;
    endtask

    task automatic put(input logic [7:0] c, input logic [7:0] v);
        rle_word_t w;
        w.count = c;
        w.value = v;
        src.push_back(w);
        for (int i = 0; i < int'(c); i++) expq.push_back(v);
        refresh();
    endtask

    task automatic step(input logic f);
        logic rd;
        logic [31:0] e;
        out_full = f;
        @(negedge clk);
        rd = in_read;
        if (rst) begin
            check("rst_read", {31'd0, in_read}, 32'd0);
            check("rst_write", {31'd0, out_write}, 32'd0);
        end
        if (f) check("full_write", {31'd0, out_write}, 32'd0);
        if (f && busy) check("full_read", {31'd0, in_read}, 32'd0);
        if (in_read) check("read_avail", {31'd0, in_avail}, 32'd1);
        if (out_write) begin
            nw++;
            e = expq.size() != 0 ? {24'd0, expq.pop_front()} : 32'hDEAD;
            check("byte", {24'd0, out_data}, e);
        end
        if (rd) np++;
        if (rd && out_write) nco++;
        @(posedge clk);
        #1;
        if (rd) begin
            void'(src.pop_front());
            refresh();
        end
    endtask

    task automatic clr();
        np = 0;
        nw = 0;
        nco = 0;
    endtask

    initial begin
        clr();
        in_avail = 1;
        in_data  = 16'h0341;
        step(0);
        step(0);
        rst = 0;
        in_avail = 0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data", {24'd0, out_data}, 32'd0);

        clr();
        put(8'h03, 8'h41);
        repeat (5) step(0);
        check("single_reads", np, 1);
        check("single_writes", nw, 3);
        check("single_busy", {31'd0, busy}, 32'd0);
        check("single_drain", expq.size(), 0);

        clr();
        put(8'h02, 8'h41);
        put(8'h01, 8'h42);
        repeat (4) step(0);
        check("b2b_writes", nw, 3);
        check("b2b_reads", np, 2);
        check("b2b_overlap", nco, 1);
        check("b2b_busy", {31'd0, busy}, 32'd0);
        check("b2b_drain", expq.size(), 0);

        clr();
        put(8'h00, 8'h55);
        put(8'h01, 8'h66);
        repeat (3) step(0);
        check("zero_reads", np, 2);
        check("zero_writes", nw, 1);
        check("zero_drain", expq.size(), 0);

        clr();
        put(8'h04, 8'h77);
        put(8'h01, 8'h88);
        step(0); step(1); step(1); step(0); step(0); step(0);
        check("bp_hold_src", src.size(), 1);
        step(1);
        check("bp_hold_pop", src.size(), 1);
        step(0); step(0); step(0);
        check("bp_writes", nw, 5);
        check("bp_reads", np, 2);
        check("bp_drain", expq.size(), 0);

        clr();
        put(8'hFF, 8'h10);
        put(8'h01, 8'h20);
        repeat (6) step(0);
        check("mid_writes", nw, 5);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        step(0);
        rst = 0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        expq.delete();
        expq.push_back(8'h20);
        clr();
        repeat (3) step(0);
        check("mid_after_reads", np, 1);
        check("mid_after_writes", nw, 1);
        check("mid_after_drain", expq.size(), 0);

`ifdef RLE_EXPAND_STATS_EN
        rst = 1;
        step(0);
        rst = 0;
        check("stat_clr_bytes", stat_bytes, 0);
        check("stat_clr_runs", stat_runs, 0);
        clr();
        put(8'h02, 8'h01);
        put(8'h00, 8'h00);
        put(8'h03, 8'h02);
        repeat (8) step(0);
        check("stat_bytes", stat_bytes, 5);
        check("stat_runs", stat_runs, 2);
        check("stat_drain", expq.size(), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rle_expand.md
Name: rle_expand

Overview:
- Downstream consumer of the RLE core's output FIFO port (16-bit word, avail/read handshake, show-ahead data).
- Decodes each run word {count, value} into `count` repeated value bytes.
- Pushes the bytes into a byte-wide write/full sink, such as the next FIFO or the host link.
- Sustains one output byte per cycle across run boundaries, with no bubble between runs.

Parameters:
- VALUE_W, 8, width of the value field and of the output byte.
- CNT_W, 8, width of the run-count field. The input word is CNT_W+VALUE_W = 16 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_data  input  16  run word: [15:8] = count, [7:0] = value. Valid whenever in_avail=1 (show-ahead).
- in_avail  input  1  upstream has a word
- in_read  output  1  pops the word. Asserted only when in_avail=1.
- out_data  output  8  expanded byte
- out_write  output  1  byte push. Asserted only when out_full=0.
- out_full  input  1  sink cannot accept a byte this cycle
- busy  output  1  a run is in progress (state RUN)

Behaviour:
- Reset: state=IDLE, remaining=0, value_q=0, busy=0.
  - in_read and out_write are forced to 0 during any cycle with rst=1.
  - out_data=0 after reset.
- States:
  - IDLE: no run loaded.
  - RUN: value_q and remaining (CNT_W bits, 1..2^CNT_W-1) are held.
- in_read (combinational) = !rst && in_avail && (state==IDLE || (state==RUN && remaining==1 && !out_full)).
- A pop captures in_data in the same cycle:
  - value_q <= in_data[7:0].
  - remaining <= in_data[15:8].
  - Next state: RUN if count!=0. If count==0, next state is IDLE; the word is consumed and no byte is emitted.
- out_write (combinational) = !rst && state==RUN && !out_full. out_data = value_q, driven continuously.
- RUN with a write:
  - If remaining>1: remaining decrements.
  - If remaining==1: the run ends. If a pop occurs in the same cycle, the new word is loaded (back-to-back runs). Otherwise the state returns to IDLE.
- RUN with out_full=1: all state holds and in_read=0 (the lookahead pop is suppressed).
- Latency: the first byte of a run appears the cycle after its pop.
  - Steady state: N bytes in N cycles per run.
  - Exception: a zero-count word costs one cycle in IDLE.
- out_full toggling mid-run: bytes are neither lost nor duplicated. Output is strictly {value repeated count} per word, in order.
- Reset mid-run: the remaining bytes are discarded. The next word is read fresh after rst deasserts.
- in_avail dropping while in RUN: has no effect until remaining==1.
- Maximum run: count=255 produces 255 bytes. Byte order matches the core's convention; no swap is performed here.

Optional Feature:
- Macro: RLE_EXPAND_STATS_EN.
- When defined, two extra output ports are added, each with a 32-bit counter:
  - stat_bytes (32): increments on every out_write.
  - stat_runs (32): increments on every pop with count!=0.
- Both counters cleared by rst, wrap modulo 2^32, and are never stalled by out_full except via out_write.
- When not defined, neither the ports nor the counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Package rle_pkg holds:
  - the VALUE_W and CNT_W constants;
  - a packed struct rle_word_t {count, value};
  - a state enum {IDLE, RUN}.
- Sub-module rle_stat_cnt: 32-bit counter with enable and sync clear, instantiated twice under RLE_EXPAND_STATS_EN.
- The core FSM stays in rle_expand.

Test Plan:
- Single run: word 0x0341, sink never full → in_read pulses once; out_write on 3 consecutive cycles with out_data=0x41; busy falls after the third byte.
- Back-to-back runs: words 0x0241 then 0x0142 available continuously → bytes 41,41,42 on 3 consecutive cycles. The second pop coincides with the last 0x41 write.
- Zero count: words 0x0055 then 0x0166 → 0x55 is never emitted; one IDLE cycle; then a single 0x66.
- Backpressure: word 0x0477 with out_full high on cycles 2 and 3 → exactly four 0x77 writes, none during full; the next word is not popped while full.
- Reset mid-run: word 0xFF10, rst asserted after 5 bytes → out_write=0 during rst; after release, the next word 0x0120 yields a single 0x20.
- Stats (macro defined): runs 0x0201, 0x0000, 0x0302 → stat_bytes=5, stat_runs=2.
